// File: rtl/io_tile_cfg_if.sv
// io_tile_cfg_if: serial config chain plus pad/lane data bundle for io_tile_cfg
interface io_tile_cfg_if #(parameter int IO_PAIRS = 4, parameter int IC_PAIRS = 10);
  logic config_in;
  logic config_out;
  logic config_enable;
  logic [IO_PAIRS-1:0] data_from_io;
  logic [IO_PAIRS-1:0] data_to_io;
  logic [IO_PAIRS-1:0] data_oe_to_io;
  logic [IC_PAIRS-1:0] data_from_ic;
  logic [IC_PAIRS-1:0] data_to_ic;
  modport master (
    output config_in, config_enable, data_from_io, data_from_ic,
    input  config_out, data_to_io, data_oe_to_io, data_to_ic
  );
  modport slave (
    input  config_in, config_enable, data_from_io, data_from_ic,
    output config_out, data_to_io, data_oe_to_io, data_to_ic
  );
endinterface

// File: rtl/io_tile_cfg.sv
// io_tile_cfg: serially configured pad/lane IO tile (clock, config_nreset, bus: chain + pad/lane data); IOTILE_SYNC_EN adds 2-flop pad synchronisers
module io_tile_cfg #(
  parameter int IO_PAIRS = 4,
  parameter int IC_PAIRS = 10
) (
  input logic clock,
  input logic config_nreset,
  io_tile_cfg_if.slave bus
);
  localparam int ICW = IC_PAIRS > 1 ? $clog2(IC_PAIRS) : 1;
  localparam int IOW = IO_PAIRS > 1 ? $clog2(IO_PAIRS) : 1;
  localparam int PIN_W = 5 + 2 * ICW;
  localparam int LANE_W = 1 + IOW;
  localparam int CFG_BITS = IO_PAIRS * PIN_W + IC_PAIRS * LANE_W;
  logic [CFG_BITS-1:0] cfg_q, cfg_d;
  logic [IO_PAIRS-1:0] in_q, in_d, out_q, out_d, oe_q, oe_d;
  logic [IO_PAIRS-1:0] pad, pin_in, io_c, oe_c, io_o, oe_o;
  logic [IC_PAIRS-1:0] ic_o;
  logic en;
  assign en = bus.config_enable;
`ifdef IOTILE_SYNC_EN
  logic [IO_PAIRS-1:0] s1_q, s1_d, s2_q, s2_d;
  always_comb begin
    s1_d = en ? s1_q : bus.data_from_io;
    s2_d = en ? s2_q : s1_q;
  end
  always_ff @(posedge clock or negedge config_nreset) begin
    if (!config_nreset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end
  assign pad = s2_q;
`else
  assign pad = bus.data_from_io;
`endif
  always_comb begin
    logic [PIN_W-1:0] f;
    f = '0;
    pin_in = '0;
    io_c = '0;
    oe_c = '0;
    io_o = '0;
    oe_o = '0;
    for (int k = 0; k < IO_PAIRS; k++) begin
      f = cfg_q[k*PIN_W +: PIN_W];
      pin_in[k] = f[0] & (f[2] ? in_q[k] : pad[k]);
      io_c[k] = f[1] & ((int'(f[5 +: ICW]) < IC_PAIRS ? bus.data_from_ic[f[5 +: ICW]] : 1'b0) ^ f[4]);
      oe_c[k] = f[1] & (f[0] ? (int'(f[5+ICW +: ICW]) < IC_PAIRS ? bus.data_from_ic[f[5+ICW +: ICW]] : 1'b0) : 1'b1);
      io_o[k] = !en & (f[3] ? out_q[k] : io_c[k]);
      oe_o[k] = !en & (f[3] ? oe_q[k] : oe_c[k]);
    end
  end
  always_comb begin
    logic [LANE_W-1:0] l;
    l = '0;
    ic_o = '0;
    for (int j = 0; j < IC_PAIRS; j++) begin
      l = cfg_q[IO_PAIRS*PIN_W + j*LANE_W +: LANE_W];
      ic_o[j] = !en & l[0] & (int'(l[LANE_W-1:1]) < IO_PAIRS ? pin_in[l[LANE_W-1:1]] : 1'b0);
    end
  end
  always_comb begin
    cfg_d = en ? {cfg_q[CFG_BITS-2:0], bus.config_in} : cfg_q;
    in_d = en ? in_q : pad;
    out_d = en ? out_q : io_c;
    oe_d = en ? oe_q : oe_c;
  end
  always_ff @(posedge clock or negedge config_nreset) begin
    if (!config_nreset) begin
      cfg_q <= '0;
      in_q <= '0;
      out_q <= '0;
      oe_q <= '0;
    end else begin
      cfg_q <= cfg_d;
      in_q <= in_d;
      out_q <= out_d;
      oe_q <= oe_d;
    end
  end
  assign bus.config_out = cfg_q[CFG_BITS-1];
  assign bus.data_to_io = io_o;
  assign bus.data_oe_to_io = oe_o;
  assign bus.data_to_ic = ic_o;
endmodule

// File: doc/io_tile_cfg.md
Name: io_tile_cfg

Overview:
Parametrised successor IO tile for the fabric edge. It sits between IO_PAIRS pads and IC_PAIRS interconnect lanes.
- Adds per-pin direction modes: off, input, output and bidirectional with output enable.
- Pad-to-lane and lane-to-pad paths are individually selectable as combinational or registered.
- Pin inversion and lane-to-pin routing are programmable.
- All settings load through the serial config chain shared with the rest of the fabric.

Parameters:
- IO_PAIRS, 4, number of pad pins.
- IC_PAIRS, 10, number of interconnect lanes.
- Derived localparams (not overridable):
  - ICW = max(1, clog2(IC_PAIRS)).
  - IOW = max(1, clog2(IO_PAIRS)).
  - PIN_W = 5 + 2*ICW.
  - LANE_W = 1 + IOW.
  - CFG_BITS = IO_PAIRS*PIN_W + IC_PAIRS*LANE_W. Defaults give 52 + 30 = 82.

Ports:
- clock  in  1  fabric clock; all flops rise-edge.
- config_nreset  in  1  asynchronous active-low reset; clears config and data flops.
- config_in  in  1  serial config data in.
- config_out  out  1  serial config data out, equal to cfg[CFG_BITS-1].
- config_enable  in  1  1 = shift config chain, data path frozen and gated.
- data_from_io  in  IO_PAIRS  pad input values.
- data_to_io  out  IO_PAIRS  pad output values.
- data_oe_to_io  out  IO_PAIRS  pad output enables, 1 = drive.
- data_from_ic  in  IC_PAIRS  lane values from interconnect.
- data_to_ic  out  IC_PAIRS  lane values to interconnect.

Behaviour:
- Reset: async assert of config_nreset (low) clears cfg, all in/out/oe flops and the optional sync flops to 0. All outputs read 0 during and after reset until configured.
- Config chain:
  - On rising clock with config_enable=1: cfg <= {cfg[CFG_BITS-2:0], config_in}. The first bit shifted ends at the MSB after CFG_BITS clocks.
  - config_enable=0: cfg holds.
- Pin k field at offset k*PIN_W:
  - [1:0] mode: 00 off, 01 in, 10 out, 11 bidir.
  - [2] in_reg, [3] out_reg, [4] out_inv.
  - [5 +: ICW] out_sel.
  - [5+ICW +: ICW] oe_sel.
- Lane j field at offset IO_PAIRS*PIN_W + j*LANE_W: [0] lane_en, [1 +: IOW] in_sel.
- Select decode: out_sel or oe_sel >= IC_PAIRS selects constant 0. in_sel >= IO_PAIRS selects constant 0.
- Pin input value pin_in[k]:
  - Modes 01 and 11: data_from_io[k], or its in-flop when in_reg=1 (1-cycle latency).
  - Modes 00 and 10: 0.
- Pin output:
  - src = data_from_ic[out_sel] ^ out_inv.
  - oe_src: 1 in mode 10, data_from_ic[oe_sel] in mode 11, 0 otherwise.
  - data_to_io[k] = src when mode is 10 or 11, else 0.
  - out_reg=1 registers both data and oe together: 1-cycle latency, no skew between them.
- Lane output: data_to_ic[j] = lane_en ? pin_in[in_sel] : 0.
- Data flops: update every clock while config_enable=0; hold their value while config_enable=1.
- config_enable=1 forces data_to_io, data_oe_to_io and data_to_ic to 0 combinationally, so no pad is driven mid-programming.
- Dropping config_enable from 1 to 0: outputs reflect the held flop contents and the new cfg from the same cycle.
- Reset asserted mid-shift: cfg returns to all-zero; a partial load is discarded.
- Multiple lanes may select the same pin (fan-out permitted). Pins never contend with each other.

Optional Feature:
IOTILE_SYNC_EN:
- Defined: every data_from_io bit passes through a 2-flop synchroniser, reset to 0, before the pin logic. Pad-to-lane latency becomes 2 cycles combinational-path or 3 cycles registered-path. Synchroniser flops hold while config_enable=1.
- Undefined: pads feed the pin logic directly, with latencies as in Behaviour.

Test Plan:
- Reset, then shift 82 zeros -> all outputs 0. config_out stays 0. A 1 shifted on cycle 0 appears at config_out after 82 clocks.
- Pin0 mode 10, out_sel=3, out_reg=0; data_from_ic=10'h008 -> data_to_io[0]=1 and data_oe_to_io[0]=1 in the same cycle. Set out_inv=1 -> data_to_io[0]=0.
- Pin1 mode 01, in_reg=1, lane 7 en with in_sel=1; pulse data_from_io[1] high for 1 cycle -> data_to_ic[7] high exactly 1 cycle later for 1 cycle. Lanes without lane_en stay 0.
- Pin2 mode 11, out_reg=1, oe_sel=5; toggle data_from_ic[5] -> data_oe_to_io[2] follows 1 cycle later, aligned with data_to_io[2]. Lane echo of pin2 sees the pad input.
- With configured pins active, raise config_enable -> all data outputs 0 the same cycle. Lower it without changing cfg -> previous values resume.
- out_sel=4'd12 (>= 10), and separately lane in_sel beyond IO_PAIRS (IO_PAIRS=3 build) -> driven value 0. Assert config_nreset mid-shift -> all outputs 0 immediately.
